serial_add_8bit: RTL

Bit-serial 8-bit adder with carry-in and carry-out. It is the additive counterpart of the combinational 8-bit borrow subtractor. It accepts a start-qualified operand pair and produces one sum bit per clock, LSB first, through a single full-adder cell. It then presents the registered sum, carry-out and signed-overflow flag with a one-cycle done pulse. It sits in the datapath where area matters more than latency.

---
 rtl/add_sub_pkg.sv | 18 +
 rtl/full_adder.sv | 13 +
 rtl/serial_add_8bit.sv | 115 +++++++++++
 3 files changed

// File: rtl/add_sub_pkg.sv
// Shared definitions for the serial add/subtract family: FSM state encoding,
// default operand width and a counter-sizing helper.
package add_sub_pkg;

    localparam int ADD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed for a counter that must reach w-1 (at least one bit).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder; the only arithmetic cell of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_8bit.sv
// Bit-serial adder: one full-adder bit per clock, LSB first, with registered
// sum, carry-out, signed overflow and a one-cycle done pulse.
module serial_add_8bit
    import add_sub_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e           state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-2:0] sh_q;
    logic [WIDTH-1:0] s_q;
    logic             c_out_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_d;

    full_adder u_fa (
        .a     (op_a_q[0]),
        .b     (op_b_q[0]),
        .c_in  (carry_q),
        .s     (fa_sum),
        .c_out (fa_carry)
    );

    // Only WIDTH-1 bits are buffered; the final bit goes straight into the result.
    assign sum_d = {fa_sum, sh_q};

    // Control FSM, operand/partial-sum shifting and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        op_a_q  <= a;
                        op_b_q  <= b;
                        carry_q <= c_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    op_a_q  <= {1'b0, op_a_q[WIDTH-1:1]};
                    op_b_q  <= {1'b0, op_b_q[WIDTH-1:1]};
                    carry_q <= fa_carry;
                    sh_q    <= {fa_sum, sh_q[WIDTH-2:1]};
                    cnt_q   <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        // carry_q here is the carry into the MSB position.
                        s_q     <= sum_d;
                        c_out_q <= fa_carry;
                        ovf_q   <= carry_q ^ fa_carry;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign s     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule
